fetch_predecode: RTL and testbench
==================================

Name: fetch_predecode

Overview:
- Fetch stage directly downstream of the PC register.
- Issues instruction-memory requests at the current pc and holds fetched words in a 2-entry queue for decode.
- Pre-decodes each fetched word: returns JAL targets and BHT-predicted conditional-branch offsets to the PC register, and generates its stall.
- Drops in-flight fetches on execute-stage redirects (jalr_taken / pr_miss).

Parameters:
- BHT_IDX_W, 6, log2 of BHT entries (64 two-bit counters, indexed by pc[BHT_IDX_W+1:2]).
- RESET_CTR, 2'b01, BHT counter value after reset (weakly not-taken).

Ports:
- clk  in  1  clock.
- clr  in  1  asynchronous active-high reset.
- pc  in  64  current fetch address from the PC register.
- pc_stall  out  1  to the PC register's stall input; low only when the PC may update this cycle.
- jal_taken  out  1  pre-decoded JAL this cycle.
- jal_addr  out  64  pc + sign-extended J-immediate.
- pr_taken  out  1  conditional branch predicted taken.
- pr_offs  out  13  B-immediate of that branch.
- redirect  in  1  execute redirect; equals jalr_taken | pr_miss seen by the PC register.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  64  fetch address.
- imem_ack  in  1  fetch complete; may assert in the same cycle as imem_req.
- imem_data  in  32  fetched word, valid with imem_ack.
- bu_valid  in  1  branch-resolution update from execute.
- bu_pc  in  64  PC of the resolved branch.
- bu_taken  in  1  actual outcome.
- ir_valid  out  1  queue head valid to decode.
- ir  out  32  head instruction.
- ir_pc  out  64  head PC.
- ir_pr_taken  out  1  prediction recorded for the head.
- dec_stall  in  1  decode not accepting; head pops when ir_valid && !dec_stall.

Behaviour:
- Reset (async, clr=1):
  - State REQ, queue empty.
  - ir_valid=0, ir=0, ir_pc=0, ir_pr_taken=0.
  - All BHT counters = RESET_CTR.
  - addr_q=0.
- States:
  - REQ: normal fetch.
  - DROP: a request is outstanding whose result must be discarded.
- REQ:
  - imem_req = (count<2); imem_addr = pc.
  - Once raised, imem_req stays high until ack; count never rises while a request is outstanding, so this holds.
- REQ with imem_ack && !redirect:
  - Enqueue {imem_data, pc, pred}; pc_stall=0.
  - JAL (opcode 1101111): jal_taken=1, jal_addr=pc+sext({imm[20:1],0}).
  - Branch (opcode 1100011): pr_offs={imm[12:1],0}, pr_taken=bht[pc idx][1]; pred=pr_taken.
  - Other opcodes: both outputs 0; the PC advances by 4.
- REQ with redirect:
  - pc_stall=0; queue cleared; jal_taken/pr_taken forced 0.
  - If imem_ack in the same cycle: data discarded, stay in REQ.
  - If a request is outstanding without ack: latch addr_q=pc and go to DROP.
- DROP:
  - imem_req=1, imem_addr=addr_q, pc_stall = !redirect.
  - On imem_ack: discard data, go to REQ.
  - Further redirects in DROP keep the state in DROP; the queue stays empty.
- pc_stall = 1 in every case not listed above (no ack, or queue full).
- Outputs jal_taken, jal_addr, pr_taken and pr_offs are combinational; they are meaningful only when pc_stall=0.
- Queue:
  - 2 entries, FIFO order.
  - Push and pop in the same cycle are allowed at any count.
  - Pop at empty is impossible (ir_valid=0).
  - A redirect clears the queue and has priority over push and pop.
- BHT:
  - On bu_valid, the indexed counter saturating-increments if bu_taken, else decrements; bounds are 00 and 11.
  - Read and update of the same index in one cycle: the read returns the pre-update value.
  - bu_valid is honoured during a redirect.
- Width rules:
  - All immediates sign-extended to 64 bits.
  - jal_addr wraps modulo 2^64.
  - Compressed instructions are not supported.

Decomposition:
- Shared package `rv_pkg`:
  - opcode constants OP_JAL=7'b1101111 and OP_BRANCH=7'b1100011.
  - fetch FSM state encoding.
  - immediate-extraction functions imm_j and imm_b.
- One sub-module, `bht`: counter array with combinational read and synchronous saturating update.

Test Plan:
- Reset, then zero-wait memory returning NOPs (0x00000013) -> pc 0x80000000, 0x80000004, … with one fetch per cycle while dec_stall=0; ir_pc follows one cycle later.
- Word 0x0100006F (jal x0,+16) at 0x80000000 -> same cycle jal_taken=1, jal_addr=0x80000010, pc_stall=0.
- Branch 0xFE000EE3 (beq,-4) at 0x80000008 -> pr_taken=0 after reset; after two bu_valid taken updates at that PC -> pr_taken=1, pr_offs=13'h1FFC.
- dec_stall=1 held -> exactly 2 entries fill, then imem_req=0 and pc_stall=1; release -> entries pop in order.
- Memory with 3-cycle latency, redirect pulse in cycle 1 of a request -> DROP entered, imem_addr holds the old address until ack, data discarded, next request at the redirected pc, no ir_valid for the dropped word.
- Async clr asserted mid-request -> ir_valid=0 immediately, state REQ, BHT counters at 01.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared fetch-side definitions: opcodes, fetch FSM
// states, queue entry layout and immediate decoders.
package rv_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam int         FQ_DEPTH  = 2;

  typedef enum logic {
    S_REQ  = 1'b0,
    S_DROP = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] ir;
    logic [63:0] pc;
    logic        pr;
  } fq_entry_t;

  function automatic logic [63:0] imm_j(
    input logic [31:0] i
  );
    return {{43{i[31]}}, i[31], i[19:12],
            i[20], i[30:21], 1'b0};
  endfunction

  function automatic logic [12:0] imm_b(
    input logic [31:0] i
  );
    return {i[31], i[7], i[30:25],
            i[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/bht.sv
// Branch history table: 2-bit saturating counters,
// combinational read, clocked update.
module bht #(
  parameter int         IDX_W     = 6,
  parameter logic [1:0] RESET_CTR = 2'b01
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [1:0]       o_rd_ctr,
  input  logic             i_upd_valid,
  input  logic [IDX_W-1:0] i_upd_idx,
  input  logic             i_upd_taken
);

  localparam int N = 2 ** IDX_W;

  logic [1:0] r_ctr [N];
  logic [1:0] w_cur;

  assign o_rd_ctr = r_ctr[i_rd_idx];
  assign w_cur    = r_ctr[i_upd_idx];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < N; i++) begin
        r_ctr[i] <= RESET_CTR;
      end
    end else if (i_upd_valid) begin
      unique case (1'b1)
        i_upd_taken && (w_cur != 2'b11):
          r_ctr[i_upd_idx] <= w_cur + 2'd1;
        !i_upd_taken && (w_cur != 2'b00):
          r_ctr[i_upd_idx] <= w_cur - 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_predecode.sv
// Fetch stage: imem request, 2-entry instruction queue,
// JAL / branch pre-decode and redirect-drop handling.
module fetch_predecode
  import rv_pkg::*;
#(
  parameter int         BHT_IDX_W = 6,
  parameter logic [1:0] RESET_CTR = 2'b01
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [63:0] pc,
  output logic        pc_stall,
  output logic        jal_taken,
  output logic [63:0] jal_addr,
  output logic        pr_taken,
  output logic [12:0] pr_offs,
  input  logic        redirect,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        bu_valid,
  input  logic [63:0] bu_pc,
  input  logic        bu_taken,
  output logic        ir_valid,
  output logic [31:0] ir,
  output logic [63:0] ir_pc,
  output logic        ir_pr_taken,
  input  logic        dec_stall
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [63:0]  r_addr_q;
  fq_entry_t    r_q0;
  fq_entry_t    r_q1;
  logic [1:0]   r_cnt;

  logic         w_req;
  logic         w_accept;
  logic         w_is_jal;
  logic         w_is_br;
  logic [1:0]   w_ctr;
  logic         w_push;
  logic         w_pop;
  logic [1:0]   w_cnt_pop;
  fq_entry_t    w_new;
  logic         w_unused;

  bht #(
    .IDX_W     (BHT_IDX_W),
    .RESET_CTR (RESET_CTR)
  ) u_bht (
    .clk         (clk),
    .clr         (clr),
    .i_rd_idx    (pc[BHT_IDX_W+1:2]),
    .o_rd_ctr    (w_ctr),
    .i_upd_valid (bu_valid),
    .i_upd_idx   (bu_pc[BHT_IDX_W+1:2]),
    .i_upd_taken (bu_taken)
  );

  assign w_unused = ^{bu_pc[63:BHT_IDX_W+2],
                      bu_pc[1:0]};

  assign w_req = (r_state == S_DROP) ||
                 (r_cnt != 2'(FQ_DEPTH));
  assign imem_req = w_req;

  assign w_is_jal = imem_data[6:0] == OP_JAL;
  assign w_is_br  = imem_data[6:0] == OP_BRANCH;

  always_comb begin
    w_state_nxt = r_state;
    imem_addr   = pc;
    pc_stall    = 1'b1;
    w_accept    = 1'b0;
    unique case (r_state)
      S_REQ: begin
        w_accept = w_req && imem_ack && !redirect;
        if (redirect) begin
          pc_stall = 1'b0;
          if (w_req && !imem_ack)
            w_state_nxt = S_DROP;
        end else if (w_accept) begin
          pc_stall = 1'b0;
        end
      end
      S_DROP: begin
        imem_addr = r_addr_q;
        pc_stall  = !redirect;
        if (imem_ack)
          w_state_nxt = S_REQ;
      end
      default: ;
    endcase
  end

  assign jal_taken = w_accept && w_is_jal;
  assign pr_taken  = w_accept && w_is_br && w_ctr[1];
  assign jal_addr  = pc + imm_j(imem_data);
  assign pr_offs   = imm_b(imem_data);

  assign w_push    = w_accept;
  assign w_pop     = (r_cnt != 2'd0) && !dec_stall;
  assign w_cnt_pop = r_cnt - {1'b0, w_pop};
  assign w_new     = '{ir: imem_data, pc: pc,
                       pr: pr_taken};

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state  <= S_REQ;
      r_addr_q <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_REQ && w_state_nxt == S_DROP)
        r_addr_q <= pc;
    end
  end

  // Redirect wins over both push and pop.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_cnt <= '0;
      r_q0  <= '0;
      r_q1  <= '0;
    end else if (redirect) begin
      r_cnt <= '0;
    end else begin
      if (w_pop)
        r_q0 <= r_q1;
      if (w_push) begin
        if (w_cnt_pop == 2'd0)
          r_q0 <= w_new;
        else
          r_q1 <= w_new;
      end
      r_cnt <= w_cnt_pop + {1'b0, w_push};
    end
  end

  assign ir_valid    = r_cnt != 2'd0;
  assign ir          = r_q0.ir;
  assign ir_pc       = r_q0.pc;
  assign ir_pr_taken = r_q0.pr;

endmodule

// File: tb/tb_fetch_predecode.sv
// Randomized bench for fetch_predecode against a
// queue-based reference model of the fetch stage.
module tb_fetch_predecode;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [63:0] BASE = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [63:0] pc = BASE;
  logic        pc_stall;
  logic        jal_taken;
  logic [63:0] jal_addr;
  logic        pr_taken;
  logic [12:0] pr_offs;
  logic        redirect = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = '0;
  logic        bu_valid = 1'b0;
  logic [63:0] bu_pc = '0;
  logic        bu_taken = 1'b0;
  logic        ir_valid;
  logic [31:0] ir;
  logic [63:0] ir_pc;
  logic        ir_pr_taken;
  logic        dec_stall = 1'b0;

  fetch_predecode dut (
    .clk         (clk),
    .clr         (clr),
    .pc          (pc),
    .pc_stall    (pc_stall),
    .jal_taken   (jal_taken),
    .jal_addr    (jal_addr),
    .pr_taken    (pr_taken),
    .pr_offs     (pr_offs),
    .redirect    (redirect),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .bu_valid    (bu_valid),
    .bu_pc       (bu_pc),
    .bu_taken    (bu_taken),
    .ir_valid    (ir_valid),
    .ir          (ir),
    .ir_pc       (ir_pc),
    .ir_pr_taken (ir_pr_taken),
    .dec_stall   (dec_stall)
  );

  always #5 clk = ~clk;

  typedef enum {K_OTHER, K_JAL, K_BR} kind_e;
  typedef struct {
    logic [31:0] w;
    kind_e       k;
    int          off;
  } mword_t;
  typedef struct {
    logic [31:0] w;
    logic [63:0] a;
    bit          p;
  } qent_t;

  mword_t      mem [logic [63:0]];
  qent_t       fq [$];
  bit          m_drop;
  logic [63:0] m_daddr;
  int          ctr [64];
  logic [63:0] m_pc_nxt = BASE;

  bit mb_busy;
  int mb_cnt, mb_lat;
  int lat_lo, lat_hi;
  int p_redir, p_stall, p_bu;
  bit          f_redir;
  logic [63:0] f_tgt;
  bit          f_bu;
  logic [63:0] f_bu_pc;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic mword_t word_at(
    input logic [63:0] a
  );
    mword_t d;
    if (mem.exists(a)) return mem[a];
    d.w = NOP;
    d.k = K_OTHER;
    d.off = 0;
    return d;
  endfunction

  function automatic logic [31:0] enc_j(input int off);
    logic [20:0] o;
    o = off[20:0];
    return {o[20], o[10:1], o[11], o[19:12],
            5'd0, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_b(input int off);
    logic [12:0] o;
    o = off[12:0];
    return {o[12], o[10:5], 5'd1, 5'd0, 3'b000,
            o[4:1], o[11], 7'b1100011};
  endfunction

  function automatic void model_reset();
    fq.delete();
    m_drop = 0;
    mb_busy = 0;
    for (int i = 0; i < 64; i++) ctr[i] = 1;
  endfunction

  task automatic step();
    bit          e_req, e_stall, e_jal, e_pr, acc, pop;
    logic [63:0] e_addr, tgt;
    logic [12:0] eo;
    mword_t      mw;
    int          idx, bi;
    @(negedge clk);
    pc = m_pc_nxt;
    redirect = f_redir ||
               ($urandom_range(0, 99) < p_redir);
    tgt = f_redir ? f_tgt :
          BASE + 64'(4 * $urandom_range(0, 255));
    f_redir = 0;
    dec_stall = $urandom_range(0, 99) < p_stall;
    if (f_bu) begin
      bu_valid = 1; bu_pc = f_bu_pc; bu_taken = 1;
      f_bu = 0;
    end else begin
      bu_valid = $urandom_range(0, 99) < p_bu;
      bu_pc = $urandom_range(0, 1) ? pc :
              BASE + 64'(4 * $urandom_range(0, 255));
      bu_taken = $urandom_range(0, 1) == 1;
    end
    e_req = m_drop || (fq.size() < 2);
    e_addr = m_drop ? m_daddr : pc;
    imem_ack = 0;
    if (e_req) begin
      if (!mb_busy) begin
        mb_busy = 1;
        mb_cnt = 0;
        mb_lat = $urandom_range(lat_lo, lat_hi);
      end
      if (mb_cnt == mb_lat) begin
        imem_ack = 1;
        mb_busy = 0;
      end else mb_cnt++;
    end
    mw = word_at(e_addr);
    imem_data = imem_ack ? mw.w : $urandom();
    acc = !m_drop && imem_ack && !redirect;
    e_stall = m_drop ? !redirect : !(redirect || acc);
    idx = int'(pc[7:2]);
    e_jal = acc && mw.k == K_JAL;
    e_pr = acc && mw.k == K_BR && ctr[idx] >= 2;
    #1;
    chk("imem_req", imem_req, e_req);
    if (e_req) chk("imem_addr", imem_addr, e_addr);
    chk("pc_stall", pc_stall, e_stall);
    chk("jal_taken", jal_taken, e_jal);
    if (e_jal)
      chk("jal_addr", jal_addr, pc + longint'(mw.off));
    chk("pr_taken", pr_taken, e_pr);
    if (acc && mw.k == K_BR) begin
      eo = 13'(mw.off);
      chk("pr_offs", pr_offs, eo);
    end
    chk("ir_valid", ir_valid, fq.size() != 0);
    if (fq.size() != 0) begin
      chk("ir", ir, fq[0].w);
      chk("ir_pc", ir_pc, fq[0].a);
      chk("ir_pr", ir_pr_taken, fq[0].p);
    end
    pop = fq.size() != 0 && !dec_stall;
    if (redirect) begin
      fq.delete();
      if (!m_drop && e_req && !imem_ack) begin
        m_drop = 1;
        m_daddr = pc;
      end else if (m_drop && imem_ack) m_drop = 0;
    end else begin
      if (pop) void'(fq.pop_front());
      if (acc) fq.push_back('{mw.w, pc, e_pr});
      if (m_drop && imem_ack) m_drop = 0;
    end
    if (bu_valid) begin
      bi = int'(bu_pc[7:2]);
      if (bu_taken && ctr[bi] < 3) ctr[bi]++;
      if (!bu_taken && ctr[bi] > 0) ctr[bi]--;
    end
    if (!e_stall) begin
      if (redirect) m_pc_nxt = tgt;
      else if (e_jal) m_pc_nxt = pc + longint'(mw.off);
      else if (e_pr) m_pc_nxt = pc + longint'(mw.off);
      else m_pc_nxt = pc + 64'd4;
    end
  endtask

  task automatic go_to(input logic [63:0] a);
    f_redir = 1;
    f_tgt = a;
    step();
  endtask

  initial begin
    bit          found;
    logic [63:0] held;
    int          o, r;
    model_reset();
    lat_lo = 0; lat_hi = 0;
    p_redir = 0; p_stall = 0; p_bu = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ir_valid", ir_valid, 0);
    chk("rst_ir", ir, 0);
    chk("rst_ir_pc", ir_pc, 0);
    chk("rst_ir_pr", ir_pr_taken, 0);
    chk("rst_req", imem_req, 1);
    @(negedge clk);
    clr = 0;

    repeat (8) step();

    mem[BASE] = '{32'h0100_006F, K_JAL, 16};
    mem[BASE + 8] = '{32'hFE00_0EE3, K_BR, -4};
    go_to(BASE);
    step();
    chk("tp_jal", jal_taken, 1);
    chk("tp_jal_addr", jal_addr, 64'h8000_0010);
    chk("tp_jal_stall", pc_stall, 0);

    go_to(BASE + 8);
    step();
    chk("tp_br_nt", pr_taken, 0);
    f_bu = 1; f_bu_pc = BASE + 8; step();
    f_bu = 1; f_bu_pc = BASE + 8; step();
    go_to(BASE + 8);
    step();
    chk("tp_br_t", pr_taken, 1);
    chk("tp_br_offs", pr_offs, 13'h1FFC);
    repeat (4) step();

    p_stall = 100;
    go_to(BASE + 64);
    repeat (5) step();
    chk("full_req", imem_req, 0);
    chk("full_stall", pc_stall, 1);
    p_stall = 0;
    repeat (4) step();

    lat_lo = 3; lat_hi = 3;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      found = mb_busy && mb_cnt == 1;
    end
    chk("lat_sync", found, 1);
    held = pc;
    go_to(BASE + 256);
    step();
    chk("drop_hold", imem_addr, held);
    repeat (8) step();

    lat_lo = 0; lat_hi = 0;
    f_bu = 1; f_bu_pc = BASE + 8; step();
    f_bu = 1; f_bu_pc = BASE + 8; step();
    lat_lo = 3; lat_hi = 3;
    repeat (2) step();
    @(negedge clk);
    redirect = 0; imem_ack = 0;
    bu_valid = 0; dec_stall = 1;
    #2 clr = 1;
    #1;
    chk("clr_ir_valid", ir_valid, 0);
    chk("clr_req", imem_req, 1);
    model_reset();
    #1 clr = 0;
    lat_lo = 0; lat_hi = 0;
    go_to(BASE + 8);
    step();
    chk("clr_bht", pr_taken, 0);

    for (int i = 0; i < 256; i++) begin
      r = $urandom_range(0, 9);
      o = $urandom_range(1, 32) * 4;
      if ($urandom_range(0, 1) == 1) o = -o;
      if (r < 6)
        mem[BASE + 64'(4 * i)] = '{NOP, K_OTHER, 0};
      else if (r < 8)
        mem[BASE + 64'(4 * i)] = '{enc_j(o), K_JAL, o};
      else
        mem[BASE + 64'(4 * i)] = '{enc_b(o), K_BR, o};
    end
    lat_lo = 0; lat_hi = 3;
    p_redir = 6; p_stall = 30; p_bu = 25;
    repeat (3000) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
